spi_master_arb: RTL
===================

// Module: spi_master_arb
// PURPOSE
//  SPI master controller that sequences the SPI bus (SCLK/MOSI/MISO/SS) on behalf of two on-chip requesters.
//  It arbitrates round-robin between the requesters and runs one WORD-bit full-duplex transfer per grant.
//  Each transfer targets the slave-select line of the granted requester.
//  Sits between the MPU-side command logic and the off-chip SPI pins.
//  Mode 0 (CPOL=0, CPHA=0), MSB first.
// PARAMETERS
//  WORD     8   bits per transfer (>=2)
//  CLK_DIV  4   CLK cycles per SCLK half-period (>=1); SCLK = f(CLK)/(2*CLK_DIV)
// PORTS
//  CLK         in   1     system clock, all logic on rising edge
//  RST         in   1     synchronous reset, active high
//  REQ0_VALID  in   1     requester 0 has a word to send
//  REQ0_DATA   in   WORD  requester 0 transmit word
//  REQ0_READY  out  1     requester 0 word accepted this cycle
//  REQ1_VALID  in   1     requester 1 has a word to send
//  REQ1_DATA   in   WORD  requester 1 transmit word
//  REQ1_READY  out  1     requester 1 word accepted this cycle
//  RSP_VALID   out  1     one-cycle pulse: received word available
//  RSP_ID      out  1     requester that owns RSP_DATA
//  RSP_DATA    out  WORD  word shifted in from MISO
//  BUSY        out  1     high in every state except IDLE
//  SCLK        out  1     SPI clock, idle low
//  MOSI        out  1     SPI data out
//  MISO        in   1     SPI data in
//  SS          out  2     active-low selects; SS[i] belongs to requester i
// BEHAVIOUR
//  Reset: state=IDLE, SS=2'b11, SCLK=0, MOSI=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, BUSY=0, READY*=0, last_grant=1.
//  Reset mid-transfer: all outputs at reset values after the next edge; the transfer is dropped with no RSP_VALID.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//  IDLE:
//   - READYi is combinational and is high only in IDLE, only for the granted requester, only while its VALID is high.
//   - Grant: if one VALID is high, grant it. If both are high, grant !last_grant.
//   - On accept (cycle 0): latch the granted DATA into tx_sr, record the grant, update last_grant.
//   - Next state is SETUP.
//  SETUP:
//   - Lasts CLK_DIV cycles; SS[g]=0 from cycle 1.
//   - MOSI = tx_sr[WORD-1] from cycle 1.
//  SHIFT:
//   - SCLK toggles every CLK_DIV cycles; first rise at cycle 1+CLK_DIV.
//   - On each rising edge, MISO is shifted into rx_sr LSB.
//   - On each falling edge (except the last), tx_sr shifts left and MOSI takes the new MSB.
//   - After 2*WORD toggles the last fall occurs at cycle 1+2*WORD*CLK_DIV, and the state moves to HOLD.
//  HOLD: SCLK=0 for CLK_DIV cycles.
//  DONE (cycle 1+(2*WORD+1)*CLK_DIV):
//   - SS=2'b11, RSP_VALID=1 for exactly one cycle.
//   - RSP_DATA=rx_sr, RSP_ID=g; both hold their values until the next DONE.
//   - Next state is IDLE.
//  Defaults give accept->RSP_VALID = 69 cycles. Next accept is earliest at DONE+1; SS stays high for >=2 cycles between transfers.
//  RSP has no backpressure. VALID dropping while not granted is legal; no request is queued internally.
//  Only one SS bit is low at any time. SCLK never toggles while SS=2'b11.
// TESTING
//  T1 reset: hold RST 3 cycles mid-random stimulus -> SS=11, SCLK=0, BUSY=0, RSP_VALID=0, READY0/1=0.
//  T2 REQ0 8'hA5, slave model drives 8'h3C:
//     -> MOSI sampled on SCLK rises = 1,0,1,0,0,1,0,1; SS=2'b10 throughout.
//     -> RSP_VALID at accept+69 with RSP_DATA=8'h3C, RSP_ID=0.
//  T3 both VALID held from reset, 4 transfers -> grant order 0,1,0,1; READY pulses never overlap.
//  T4 REQ1 held with 3 words, REQ0 idle -> three consecutive grants to 1; SS=2'b01 during each transfer.
//  T5 RST asserted 30 cycles after accept -> SS=11, SCLK=0 next cycle, no RSP_VALID; following REQ0 8'h5A completes normally.
//  T6 WORD=16, CLK_DIV=1, REQ0 16'hBEEF, loopback MOSI->MISO -> RSP_DATA=16'hBEEF at accept+34.

Source files
------------

// File: rtl/spi_master_arb.sv
// spi_master_arb
//   SPI master (mode 0, MSB first) shared by two on-chip requesters.
//   Requests are granted round-robin. Each grant runs one WORD-bit
//   full-duplex transfer on the requester's own slave select. The received
//   word comes back on the rsp_* pulse.
//
// Ports
//   clk, rst                 system clock; synchronous active-high reset
//   req0_valid/data/ready    requester 0 transmit handshake
//   req1_valid/data/ready    requester 1 transmit handshake
//   rsp_valid/id/data        one-cycle response pulse; id/data hold until next
//   busy                     high whenever the FSM is not in IDLE
//   sclk, mosi, miso, ss     SPI pins (ss active low, ss[i] for requester i)
//   dbg_state                current FSM state (IDLE=0 .. DONE=4)
//
// Handshake: a request word is accepted on a rising clk edge where
//   reqN_valid && reqN_ready. ready is combinational, high only in IDLE,
//   only for the granted requester and only while its valid is high.
//   Nothing is queued: a valid that drops before being granted is simply
//   forgotten. The response side has no backpressure.
module spi_master_arb #(
  parameter int WORD    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [WORD-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [WORD-1:0] req1_data,
  output logic            req1_ready,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [WORD-1:0] rsp_data,
  output logic            busy,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic [1:0]      ss,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(2 * WORD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(2 * WORD - 1);

  state_t          state;
  logic [CW-1:0]   cnt;         // clk cycles within one SCLK half-period
  logic [TW-1:0]   tog;         // SCLK toggles issued so far
  logic            grant;       // requester owning the current transfer
  logic            last_grant;
  // The MSB goes straight to mosi on accept, so only the remaining
  // WORD-1 bits need to be kept for shifting.
  logic [WORD-2:0] tx_sr;
  logic [WORD-1:0] rx_sr;

  logic            gnt_sel;
  logic            accept;
  logic [WORD-1:0] gnt_data;
  logic            half_done;

  // Round-robin: contention goes to the requester not served last time.
  always_comb begin
    gnt_sel = req1_valid;
    if (req0_valid && req1_valid) gnt_sel = ~last_grant;
  end

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !gnt_sel;
  assign req1_ready = !rst && (state == IDLE) && req1_valid &&  gnt_sel;
  assign accept     = req0_ready || req1_ready;
  assign gnt_data   = gnt_sel ? req1_data : req0_data;
  assign half_done  = (cnt == CNT_LAST);

  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ss         <= 2'b11;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      tog        <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sr      <= gnt_data[WORD-2:0];
            mosi       <= gnt_data[WORD-1];
            grant      <= gnt_sel;
            last_grant <= gnt_sel;
            ss         <= gnt_sel ? 2'b01 : 2'b10;
            cnt        <= '0;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (half_done) begin
            // First rising SCLK edge: sample the first MISO bit with it.
            cnt   <= '0;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[WORD-2:0], miso};
            tog   <= TW'(1);
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (half_done) begin
            cnt  <= '0;
            tog  <= tog + 1'b1;
            sclk <= ~sclk;
            if (!sclk) begin
              rx_sr <= {rx_sr[WORD-2:0], miso};
            end else if (tog == TOG_LAST) begin
              // Final falling edge: no further bit to present.
              state <= HOLD;
            end else begin
              mosi  <= tx_sr[WORD-2];
              tx_sr <= tx_sr << 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (half_done) begin
            cnt       <= '0;
            ss        <= 2'b11;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sr;
            rsp_id    <= grant;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
